// File: rtl/ifu.sv
// Instruction fetch unit: keeps the PC, issues one outstanding instruction-memory
// request at a time and buffers each response for the if_id handshake.
module ifu #(
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0000,
    parameter logic [31:0] INST_NOP  = 32'h0000_0013,
    parameter int          HOLD_W    = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              jump_flag_i,
    input  logic [31:0]       jump_addr_i,
    input  logic [HOLD_W-1:0] hold_flag_i,
    input  logic [7:0]        int_flag_i,
    output logic              mem_req_o,
    output logic [31:0]       mem_addr_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [31:0]       mem_rdata_i,
    output logic [31:0]       inst_o,
    output logic [31:0]       inst_addr_o,
    output logic              inst_addr_next_type_o,
    output logic [7:0]        int_flag_o,
    output logic              instr_ready_o,
    input  logic              instr_req_i
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        discard_q, discard_d;
    logic        buf_vld_q, buf_vld_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_addr_q, inst_addr_d;
    logic        next_type_q, next_type_d;
    logic [7:0]  int_flag_q, int_flag_d;

    logic        xfer, granted, resp, accept, is_jal;
    logic [31:0] jal_imm;

    always_comb begin
        xfer    = buf_vld_q & instr_req_i;
        granted = (state_q == S_REQ) & mem_gnt_i;
        resp    = (state_q == S_WAIT) & mem_rvalid_i;
        accept  = resp & ~discard_q & ~jump_flag_i;
        is_jal  = (mem_rdata_i[6:0] == 7'b1101111);
        jal_imm = {{11{mem_rdata_i[31]}}, mem_rdata_i[31], mem_rdata_i[19:12],
                   mem_rdata_i[20], mem_rdata_i[30:21], 1'b0};

        state_d     = state_q;
        pc_d        = pc_q;
        discard_d   = discard_q;
        buf_vld_d   = buf_vld_q;
        inst_d      = inst_q;
        inst_addr_d = inst_addr_q;
        next_type_d = next_type_q;
        int_flag_d  = int_flag_q;

        case (state_q)
            S_IDLE:  if (hold_flag_i == '0 && (!buf_vld_q || xfer)) state_d = S_REQ;
            S_REQ:   if (mem_gnt_i) state_d = S_WAIT;
            S_WAIT:  if (mem_rvalid_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (resp) discard_d = 1'b0;
        if (xfer) buf_vld_d = 1'b0;

        if (accept) begin
            buf_vld_d   = 1'b1;
            inst_d      = mem_rdata_i;
            inst_addr_d = pc_q;
            int_flag_d  = int_flag_i;
            next_type_d = is_jal;
            pc_d        = is_jal ? pc_q + jal_imm : pc_q + 32'd4;
        end

        // A response landing in the jump cycle is simply dropped, so only a
        // still-pending request needs to be marked for discard.
        if (jump_flag_i) begin
            pc_d      = jump_addr_i;
            buf_vld_d = 1'b0;
            if (granted || (state_q == S_WAIT && !mem_rvalid_i)) discard_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            pc_q        <= BOOT_ADDR;
            discard_q   <= 1'b0;
            buf_vld_q   <= 1'b0;
            inst_q      <= INST_NOP;
            inst_addr_q <= 32'd0;
            next_type_q <= 1'b0;
            int_flag_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            discard_q   <= discard_d;
            buf_vld_q   <= buf_vld_d;
            inst_q      <= inst_d;
            inst_addr_q <= inst_addr_d;
            next_type_q <= next_type_d;
            int_flag_q  <= int_flag_d;
        end
    end

    assign mem_req_o             = (state_q == S_REQ);
    assign mem_addr_o            = pc_q;
    assign inst_o                = inst_q;
    assign inst_addr_o           = inst_addr_q;
    assign inst_addr_next_type_o = next_type_q;
    assign int_flag_o            = int_flag_q;
    assign instr_ready_o         = buf_vld_q;

endmodule
